// File: rtl/serializador_2d_if.sv
// Load/transmit bundle for serializador_2d: frame loading, start/mode control
// and the valid/ready serial output stream.
interface serializador_2d_if #(
  parameter int tamanyo = 32,
  parameter int size    = 8
);
  logic                       wr_en;
  logic [size-1:0]            wr_data;
  logic                       start;
  logic                       modo;
  logic [$clog2(tamanyo)-1:0] seleccion;
  logic                       lleno;
  logic                       ocupado;
  logic                       valido;
  logic                       listo;
  logic [size-1:0]            dato_serie;
  logic                       fin;

  modport master (
    output wr_en, wr_data, start, modo, seleccion, listo,
    input  lleno, ocupado, valido, dato_serie, fin
  );

  modport slave (
    input  wr_en, wr_data, start, modo, seleccion, listo,
    output lleno, ocupado, valido, dato_serie, fin
  );
endinterface

// File: rtl/serializador_2d.sv
// Frame buffer that loads tamanyo words, then streams the whole frame or a
// selectable prefix out over a valid/ready handshake.
module serializador_2d #(
  parameter int tamanyo = 32,
  parameter int size    = 8
) (
  input logic               clock,
  input logic               reset,
  input logic               clear,
  serializador_2d_if.slave  bus
);
  localparam int AW = (tamanyo > 1) ? $clog2(tamanyo) : 1;
  localparam int CW = $clog2(tamanyo + 1);
  localparam int SW = $clog2(tamanyo);

  typedef enum logic [1:0] {CARGA, LLENO, ENVIO} state_t;

  state_t          state;
  logic [size-1:0] mem [tamanyo];
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   len;
  logic [CW-1:0]   rd_nxt;
  logic            lleno_q;
  logic            ocupado_q;
  logic            valido_q;
  logic            fin_q;
  logic [size-1:0] dato_q;

  // seleccion+1 is formed one bit wider so it cannot wrap before saturation.
  function automatic logic [CW-1:0] sat_len(input logic m, input logic [SW-1:0] sel);
    logic [SW:0] p1;
    p1 = {1'b0, sel} + (SW+1)'(1);
    if (!m || p1 > (SW+1)'(tamanyo)) return CW'(tamanyo);
    return CW'(p1);
  endfunction

  assign rd_nxt = rd_ptr + CW'(1);

  // Buffer is data only: no reset, written solely while loading and not flushed.
  always_ff @(posedge clock) begin
    if (state == CARGA && clear && bus.wr_en)
      mem[wr_cnt[AW-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= CARGA;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      len       <= '0;
      lleno_q   <= 1'b0;
      ocupado_q <= 1'b0;
      valido_q  <= 1'b0;
      fin_q     <= 1'b0;
      dato_q    <= '0;
    end else begin
      fin_q <= 1'b0;
      if (!clear) begin
        state     <= CARGA;
        wr_cnt    <= '0;
        rd_ptr    <= '0;
        lleno_q   <= 1'b0;
        ocupado_q <= 1'b0;
        valido_q  <= 1'b0;
        dato_q    <= '0;
      end else begin
        case (state)
          CARGA: begin
            if (bus.wr_en) begin
              wr_cnt <= wr_cnt + CW'(1);
              if (wr_cnt == CW'(tamanyo - 1)) begin
                state   <= LLENO;
                lleno_q <= 1'b1;
              end
            end
          end
          LLENO: begin
            if (bus.start) begin
              len       <= sat_len(bus.modo, bus.seleccion);
              rd_ptr    <= '0;
              state     <= ENVIO;
              lleno_q   <= 1'b0;
              ocupado_q <= 1'b1;
              valido_q  <= 1'b1;
              dato_q    <= mem[0];
            end
          end
          ENVIO: begin
            // Output word is preloaded from the next pointer so it is registered.
            if (bus.listo) begin
              if (rd_ptr == len - CW'(1)) begin
                state     <= CARGA;
                wr_cnt    <= '0;
                rd_ptr    <= '0;
                ocupado_q <= 1'b0;
                valido_q  <= 1'b0;
                dato_q    <= '0;
                fin_q     <= 1'b1;
              end else begin
                rd_ptr <= rd_nxt;
                dato_q <= mem[rd_nxt[AW-1:0]];
              end
            end
          end
          default: state <= CARGA;
        endcase
      end
    end
  end

  assign bus.lleno      = lleno_q;
  assign bus.ocupado    = ocupado_q;
  assign bus.valido     = valido_q;
  assign bus.fin        = fin_q;
  assign bus.dato_serie = dato_q;
endmodule

// File: tb/tb_serializador_2d.sv
// Directed bench for serializador_2d with a 4-word, 8-bit frame.
module tb_serializador_2d;
  localparam int T = 4;
  localparam int S = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b1;
  int   cmp   = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  serializador_2d_if #(.tamanyo(T), .size(S)) bus ();

  serializador_2d #(.tamanyo(T), .size(S)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_frame(input logic [7:0] w0, w1, w2, w3);
    logic [7:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = w[i];
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    cmp++;
    if ({bus.lleno, bus.ocupado, bus.valido, bus.fin, bus.dato_serie} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got %h, want 000",
               {bus.lleno, bus.ocupado, bus.valido, bus.fin, bus.dato_serie});
    end
    tick();
    tick();
    cmp++;
    if ({bus.lleno, bus.ocupado, bus.valido, bus.fin, bus.dato_serie} !== 12'h000) begin
      bad++;
      $display("FAIL reset_clocked: got %h, want 000",
               {bus.lleno, bus.ocupado, bus.valido, bus.fin, bus.dato_serie});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    logic [7:0] e [4];
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_frame(8'h11, 8'h22, 8'h33, 8'h44);
    cmp++;
    if ({bus.lleno, bus.ocupado} !== 2'b10) begin
      bad++;
      $display("FAIL full_lleno: got %b, want 10", {bus.lleno, bus.ocupado});
    end
    bus.modo = 1'b0; bus.start = 1'b1; bus.listo = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if ({bus.ocupado, bus.valido, bus.dato_serie} !== {2'b11, e[i]}) begin
        bad++;
        $display("FAIL full_word[%0d]: got %h, want %h", i,
                 {bus.ocupado, bus.valido, bus.dato_serie}, {2'b11, e[i]});
      end
      tick();
    end
    cmp++;
    if ({bus.fin, bus.valido, bus.lleno, bus.ocupado, bus.dato_serie} !== {4'b1000, 8'h00}) begin
      bad++;
      $display("FAIL full_fin: got %h, want 800",
               {bus.fin, bus.valido, bus.lleno, bus.ocupado, bus.dato_serie});
    end
    tick();
    cmp++;
    if (bus.fin !== 1'b0) begin
      bad++;
      $display("FAIL full_fin_once: got %b, want 0", bus.fin);
    end
  endtask

  task automatic test_prefix();
    load_frame(8'h11, 8'h22, 8'h33, 8'h44);
    bus.modo = 1'b1; bus.seleccion = 2'd1; bus.start = 1'b1; bus.listo = 1'b1;
    tick();
    bus.start = 1'b0; bus.modo = 1'b0; bus.seleccion = 2'd0;
    cmp++;
    if ({bus.valido, bus.dato_serie} !== 9'h111) begin
      bad++;
      $display("FAIL prefix_w0: got %h, want 111", {bus.valido, bus.dato_serie});
    end
    tick();
    cmp++;
    if ({bus.valido, bus.dato_serie} !== 9'h122) begin
      bad++;
      $display("FAIL prefix_w1: got %h, want 122", {bus.valido, bus.dato_serie});
    end
    tick();
    cmp++;
    if ({bus.fin, bus.valido, bus.ocupado} !== 3'b100) begin
      bad++;
      $display("FAIL prefix_fin: got %b, want 100", {bus.fin, bus.valido, bus.ocupado});
    end
    // Shortest prefix: seleccion=0 sends exactly one word.
    load_frame(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    bus.modo = 1'b1; bus.seleccion = 2'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.modo = 1'b0;
    cmp++;
    if ({bus.valido, bus.dato_serie} !== 9'h15A) begin
      bad++;
      $display("FAIL prefix1_w0: got %h, want 15a", {bus.valido, bus.dato_serie});
    end
    tick();
    cmp++;
    if ({bus.fin, bus.valido} !== 2'b10) begin
      bad++;
      $display("FAIL prefix1_fin: got %b, want 10", {bus.fin, bus.valido});
    end
  endtask

  task automatic test_stall();
    logic [7:0] e [4];
    bit         pat [9];
    int         idx;
    e   = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    pat = '{1, 0, 0, 1, 0, 1, 0, 0, 1};
    idx = 0;
    load_frame(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    bus.modo = 1'b0; bus.start = 1'b1; bus.listo = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cmp++;
      if ({bus.valido, bus.dato_serie} !== {1'b1, e[idx]}) begin
        bad++;
        $display("FAIL stall_cycle[%0d]: got %h, want %h", k,
                 {bus.valido, bus.dato_serie}, {1'b1, e[idx]});
      end
      bus.listo = pat[k];
      tick();
      if (pat[k]) idx++;
    end
    cmp++;
    if ({bus.fin, bus.valido} !== 2'b10) begin
      bad++;
      $display("FAIL stall_fin: got %b, want 10", {bus.fin, bus.valido});
    end
    bus.listo = 1'b1;
  endtask

  task automatic test_start_during_load();
    logic [7:0] e [4];
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.wr_en = 1'b1; bus.wr_data = 8'h11; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cmp++;
    if ({bus.ocupado, bus.valido, bus.lleno} !== 3'b000) begin
      bad++;
      $display("FAIL early_start: got %b, want 000", {bus.ocupado, bus.valido, bus.lleno});
    end
    for (int i = 1; i < 4; i++) begin
      bus.wr_data = e[i];
      tick();
    end
    bus.wr_data = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    cmp++;
    if ({bus.lleno, bus.ocupado} !== 2'b10) begin
      bad++;
      $display("FAIL fifth_write_lleno: got %b, want 10", {bus.lleno, bus.ocupado});
    end
    bus.start = 1'b1; bus.listo = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if ({bus.valido, bus.dato_serie} !== {1'b1, e[i]}) begin
        bad++;
        $display("FAIL load5_word[%0d]: got %h, want %h", i,
                 {bus.valido, bus.dato_serie}, {1'b1, e[i]});
      end
      tick();
    end
    cmp++;
    if (bus.fin !== 1'b1) begin
      bad++;
      $display("FAIL load5_fin: got %b, want 1", bus.fin);
    end
  endtask

  task automatic test_clear();
    logic [7:0] e [4];
    e = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    load_frame(8'h11, 8'h22, 8'h33, 8'h44);
    bus.start = 1'b1; bus.listo = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    cmp++;
    if ({bus.valido, bus.dato_serie} !== 9'h133) begin
      bad++;
      $display("FAIL clear_pre: got %h, want 133", {bus.valido, bus.dato_serie});
    end
    clear = 1'b0; bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    clear = 1'b1; bus.wr_en = 1'b0;
    cmp++;
    if ({bus.lleno, bus.ocupado, bus.valido, bus.fin, bus.dato_serie} !== 12'h000) begin
      bad++;
      $display("FAIL clear_outputs: got %h, want 000",
               {bus.lleno, bus.ocupado, bus.valido, bus.fin, bus.dato_serie});
    end
    tick();
    cmp++;
    if (bus.fin !== 1'b0) begin
      bad++;
      $display("FAIL clear_no_fin: got %b, want 0", bus.fin);
    end
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = e[i];
      tick();
    end
    bus.wr_en = 1'b0;
    cmp++;
    if (bus.lleno !== 1'b0) begin
      bad++;
      $display("FAIL clear_three_writes: got lleno %b, want 0", bus.lleno);
    end
    bus.wr_en = 1'b1; bus.wr_data = e[3];
    tick();
    bus.wr_en = 1'b0;
    cmp++;
    if (bus.lleno !== 1'b1) begin
      bad++;
      $display("FAIL clear_four_writes: got lleno %b, want 1", bus.lleno);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if ({bus.valido, bus.dato_serie} !== {1'b1, e[i]}) begin
        bad++;
        $display("FAIL clear_reload[%0d]: got %h, want %h", i,
                 {bus.valido, bus.dato_serie}, {1'b1, e[i]});
      end
      tick();
    end
    cmp++;
    if (bus.fin !== 1'b1) begin
      bad++;
      $display("FAIL clear_reload_fin: got %b, want 1", bus.fin);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e [4];
    e = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    load_frame(8'h11, 8'h22, 8'h33, 8'h44);
    bus.start = 1'b1; bus.listo = 1'b1;
    tick();
    bus.start = 1'b0;
    cmp++;
    if ({bus.ocupado, bus.valido, bus.dato_serie} !== 10'h311) begin
      bad++;
      $display("FAIL areset_pre: got %h, want 311", {bus.ocupado, bus.valido, bus.dato_serie});
    end
    #2 reset = 1'b0;
    #1;
    cmp++;
    if ({bus.lleno, bus.ocupado, bus.valido, bus.fin, bus.dato_serie} !== 12'h000) begin
      bad++;
      $display("FAIL areset_immediate: got %h, want 000",
               {bus.lleno, bus.ocupado, bus.valido, bus.fin, bus.dato_serie});
    end
    tick();
    #2 reset = 1'b1;
    tick();
    cmp++;
    if ({bus.lleno, bus.ocupado, bus.valido, bus.fin} !== 4'b0000) begin
      bad++;
      $display("FAIL areset_release: got %b, want 0000",
               {bus.lleno, bus.ocupado, bus.valido, bus.fin});
    end
    load_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if ({bus.valido, bus.dato_serie} !== {1'b1, e[i]}) begin
        bad++;
        $display("FAIL areset_reload[%0d]: got %h, want %h", i,
                 {bus.valido, bus.dato_serie}, {1'b1, e[i]});
      end
      tick();
    end
    cmp++;
    if (bus.fin !== 1'b1) begin
      bad++;
      $display("FAIL areset_reload_fin: got %b, want 1", bus.fin);
    end
  endtask

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.start     = 1'b0;
    bus.modo      = 1'b0;
    bus.seleccion = '0;
    bus.listo     = 1'b0;
    test_reset();
    test_full_frame();
    test_prefix();
    test_stall();
    test_start_during_load();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
